spike_aer_encoder: RTL and testbench
====================================

Name: spike_aer_encoder

Overview:
- Downstream of the time-multiplexed LIF neuron array.
- Captures the array's 8-bit spike vector on each time-step strobe and serialises it into address-event (AER) words: neuron address plus time-step stamp.
- Buffers events in a FIFO behind a valid/ready output port.
- Keeps overrun and drop statistics for the readout/host side.

Parameters:
DEPTH, 8, FIFO depth in events; power of two, >= 2
TS_W, 8, time-step counter and timestamp width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
spike  input  8  spike vector from neuron array, bit i = neuron i
spike_valid  input  1  one-cycle strobe: spike vector is a completed time step
aer_ready  input  1  consumer accepts the current event
drop_clr  input  1  synchronous clear of drop_count and overrun
aer_valid  output  1  event available on aer_addr/aer_ts
aer_addr  output  3  neuron index of head event
aer_ts  output  TS_W  time step of head event
fifo_count  output  $clog2(DEPTH)+1  events currently stored
drop_count  output  8  saturating count of dropped spikes
overrun  output  1  sticky: at least one spike vector discarded

Behaviour:
- Reset (async assert, sync deassert at clk): pending=0, pend_ts=0, ts_cnt=0, FIFO empty, aer_valid=0, aer_addr=0, aer_ts=0, fifo_count=0, drop_count=0, overrun=0. Reset mid-operation discards all pending and queued events immediately.
- Time-step counter:
  - ts_cnt increments by 1 on every spike_valid, including all-zero vectors.
  - Wraps modulo 2^TS_W.
- Capture, on spike_valid:
  - If pending==0: pending<=spike, pend_ts<=ts_cnt (the pre-increment value).
  - If pending!=0: the entire incoming vector is discarded. drop_count += popcount(spike), saturating at 255. overrun<=1 if spike!=0. pending and pend_ts are unchanged.
- Serialiser:
  - Each cycle with pending!=0 and fifo_count<DEPTH: write {lowest-index set bit of pending, pend_ts} into the FIFO and clear that bit.
  - Fixed priority, lowest index first; at most one write per cycle.
  - A full FIFO blocks the write even if a pop occurs the same cycle.
- Same-cycle capture and drain:
  - A spike_valid in the same cycle that the last pending bit is written sees pending!=0 and is dropped.
  - Capture is only possible once pending==0 at the sampling edge.
- FIFO:
  - First-word-fall-through, DEPTH entries, circular read/write pointers that wrap at DEPTH.
  - aer_valid = (fifo_count!=0). aer_addr/aer_ts always reflect the head entry.
  - Pop on aer_valid && aer_ready.
  - Simultaneous push and pop when non-empty: fifo_count unchanged.
  - aer_addr/aer_ts hold stable while aer_valid && !aer_ready.
- Latency:
  - spike_valid sampled at edge E0; first event written at E1; aer_valid high after E1.
  - With aer_ready=1, k spikes drain at one event per cycle.
- Stats:
  - drop_clr zeroes drop_count and overrun at the next edge.
  - drop_clr has priority over a same-cycle drop; that cycle's drops are not counted.
- No combinational path from spike/spike_valid to any output; outputs are registered or derived from FIFO state only.

Test Plan:
- Reset: assert rst mid-stream with 3 events queued -> aer_valid=0, fifo_count=0, drop_count=0, overrun=0 asynchronously; after release, next strobe produces ts 0.
- Ordering/latency: aer_ready=1, spike=8'hA5 strobed at ts_cnt=0 -> aer_valid rises after E1; events (addr,ts) = (0,0),(2,0),(5,0),(7,0) on consecutive cycles, then aer_valid=0.
- Backpressure/overrun:
  - DEPTH=8, aer_ready=0, strobe 8'hFF -> fifo_count=8.
  - Strobe 8'h03 -> captured into pending, stalled.
  - Strobe 8'h0F -> discarded; drop_count=4, overrun=1.
  - Raise aer_ready -> 8+2 events drain; no event from the discarded vector appears.
- Timestamp wrap: TS_W=8, 256 strobes with spike=0, then strobe 8'h01 -> event (0,0); a further strobe 8'h80 -> event (7,1).
- Simultaneous push/pop: keep FIFO at 4 entries with aer_ready=1 while serialising 8'hFF -> fifo_count steady, no event lost or duplicated, total 8 events in index order.
- Stats saturation/clear:
  - Force drops beyond 255 -> drop_count holds 255.
  - Assert drop_clr in the same cycle as a dropped 8'h01 -> drop_count=0, overrun=0.

Source files
------------

// File: rtl/spike_aer_encoder_if.sv
// AER output port: valid/ready handshake carrying neuron address and timestamp.
interface spike_aer_encoder_if #(
  parameter int unsigned TS_W = 8
);
  logic            aer_valid;
  logic            aer_ready;
  logic [2:0]      aer_addr;
  logic [TS_W-1:0] aer_ts;

  modport master (output aer_valid, output aer_addr, output aer_ts, input aer_ready);
  modport slave  (input aer_valid, input aer_addr, input aer_ts, output aer_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// Spike-vector to AER encoder: captures a time step's spike vector, serialises it
// lowest neuron first into a FWFT event FIFO, and tracks dropped spikes.
module spike_aer_encoder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             spike,
  input  logic                   spike_valid,
  input  logic                   drop_clr,
  spike_aer_encoder_if.master    aer,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_count,
  output logic                   overrun
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]      r_pending;
  logic [TS_W-1:0] r_pend_ts;
  logic [TS_W-1:0] r_ts_cnt;
  logic [2:0]      r_mem_addr [DEPTH];
  logic [TS_W-1:0] r_mem_ts   [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_drop;
  logic            r_overrun;

  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_drop;
  logic [2:0]      w_low_idx;
  logic [3:0]      w_popcnt;
  logic [8:0]      w_drop_sum;

  // Lowest set bit of pending (scan high to low so the lowest index wins).
  always_comb begin
    w_low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = 3'(i);
    end
  end

  // Number of spikes in the incoming vector, used for drop accounting.
  always_comb begin
    w_popcnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_popcnt = w_popcnt + 4'(spike[i]);
    end
  end

  // A full FIFO blocks the write even when a pop happens in the same cycle.
  assign w_push     = (r_pending != 8'd0) && (r_count < CW'(DEPTH));
  assign w_pop      = (r_count != '0) && aer.aer_ready;
  assign w_capture  = spike_valid && (r_pending == 8'd0);
  assign w_drop     = spike_valid && (r_pending != 8'd0);
  assign w_drop_sum = 9'(r_drop) + 9'(w_popcnt);

  // Time-step counter and pending-vector capture/serialisation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts_cnt  <= '0;
      r_pending <= 8'd0;
      r_pend_ts <= '0;
    end else begin
      if (spike_valid) r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (w_capture) begin
        r_pending <= spike;
        r_pend_ts <= r_ts_cnt;
      end else if (w_push) begin
        r_pending[w_low_idx] <= 1'b0;
      end
    end
  end

  // Event FIFO storage, circular pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_addr[i] <= 3'd0;
        r_mem_ts[i]   <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_addr[r_wr_ptr] <= w_low_idx;
        r_mem_ts[r_wr_ptr]   <= r_pend_ts;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop statistics; a clear wins over a drop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop    <= 8'd0;
      r_overrun <= 1'b0;
    end else if (drop_clr) begin
      r_drop    <= 8'd0;
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_drop <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
      if (spike != 8'd0) r_overrun <= 1'b1;
    end
  end

  assign aer.aer_valid = (r_count != '0);
  assign aer.aer_addr  = r_mem_addr[r_rd_ptr];
  assign aer.aer_ts    = r_mem_ts[r_rd_ptr];
  assign fifo_count    = r_count;
  assign drop_count    = r_drop;
  assign overrun       = r_overrun;
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder with hand-computed expected events.
module tb_spike_aer_encoder;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TS_W  = 8;

  logic       clk;
  logic       rst;
  logic [7:0] spike;
  logic       spike_valid;
  logic       drop_clr;
  logic [3:0] fifo_count;
  logic [7:0] drop_count;
  logic       overrun;

  int total;
  int bad;
  int q_addr[$];
  int q_ts[$];
  int cyc;

  spike_aer_encoder_if #(.TS_W(TS_W)) u_if ();

  spike_aer_encoder #(.DEPTH(DEPTH), .TS_W(TS_W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .spike       (spike),
    .spike_valid (spike_valid),
    .drop_clr    (drop_clr),
    .aer         (u_if.master),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] v);
    spike       = v;
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    spike       = 8'd0;
  endtask

  // Record head events (popped by aer_ready=1) until n are seen or the budget expires.
  task automatic collect(input int n, input int budget, output int cycles);
    int got;
    got    = 0;
    cycles = 0;
    while (got < n && cycles < budget) begin
      if (u_if.aer_valid) begin
        q_addr.push_back(int'(u_if.aer_addr));
        q_ts.push_back(int'(u_if.aer_ts));
        got++;
      end
      tick();
      cycles++;
    end
    if (got < n) chk("collect_timeout", 32'(got), 32'(n));
  endtask

  task automatic expect_ev(input string tag, input int a, input int t);
    if (q_addr.size() == 0) begin
      chk($sformatf("%s_missing", tag), 32'd0, 32'd1);
    end else begin
      chk($sformatf("%s_addr", tag), 32'(q_addr.pop_front()), 32'(a));
      chk($sformatf("%s_ts", tag), 32'(q_ts.pop_front()), 32'(t));
    end
  endtask

  initial begin
    int a5_idx[4];
    total = 0;
    bad   = 0;
    a5_idx = '{0, 2, 5, 7};
    rst         = 1'b1;
    spike       = 8'd0;
    spike_valid = 1'b0;
    drop_clr    = 1'b0;
    u_if.aer_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(u_if.aer_valid), 32'd0);
    chk("rst_addr", 32'(u_if.aer_addr), 32'd0);
    chk("rst_ts", 32'(u_if.aer_ts), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Ordering and latency: A5 at ts 0.
    u_if.aer_ready = 1'b1;
    strobe(8'hA5);
    chk("lat_e0_valid", 32'(u_if.aer_valid), 32'd0);
    tick();
    chk("lat_e1_valid", 32'(u_if.aer_valid), 32'd1);
    collect(4, 12, cyc);
    chk("a5_cycles", 32'(cyc), 32'd4);
    for (int i = 0; i < 4; i++) expect_ev($sformatf("a5_%0d", i), a5_idx[i], 0);
    chk("a5_empty", 32'(u_if.aer_valid), 32'd0);

    // Backpressure and overrun: FF at ts 1, 03 at ts 2 stalled, 0F at ts 3 dropped.
    u_if.aer_ready = 1'b0;
    strobe(8'hFF);
    repeat (8) tick();
    chk("bp_full", 32'(fifo_count), 32'd8);
    strobe(8'h03);
    chk("bp_stall_count", 32'(fifo_count), 32'd8);
    chk("bp_stall_drop", 32'(drop_count), 32'd0);
    strobe(8'h0F);
    chk("bp_drop", 32'(drop_count), 32'd4);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_count", 32'(fifo_count), 32'd8);
    u_if.aer_ready = 1'b1;
    collect(10, 30, cyc);
    for (int i = 0; i < 8; i++) expect_ev($sformatf("bp_%0d", i), i, 1);
    expect_ev("bp_8", 0, 2);
    expect_ev("bp_9", 1, 2);
    repeat (3) tick();
    chk("bp_no_extra", 32'(u_if.aer_valid), 32'd0);
    chk("bp_count_end", 32'(fifo_count), 32'd0);

    // Asynchronous reset with 3 events queued (ts_cnt is 4 here).
    u_if.aer_ready = 1'b0;
    strobe(8'h07);
    repeat (3) tick();
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(u_if.aer_valid), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    tick();
    rst = 1'b0;
    u_if.aer_ready = 1'b1;
    strobe(8'h01);
    collect(1, 6, cyc);
    expect_ev("post_rst", 0, 0);

    // Timestamp wrap: ts_cnt is 1, 255 empty strobes bring it back to 0.
    spike       = 8'd0;
    spike_valid = 1'b1;
    repeat (255) tick();
    spike_valid = 1'b0;
    strobe(8'h01);
    collect(1, 6, cyc);
    expect_ev("wrap0", 0, 0);
    strobe(8'h80);
    collect(1, 6, cyc);
    expect_ev("wrap1", 7, 1);

    // Simultaneous push/pop: FF at ts 2, FIFO held at 4 entries while draining.
    u_if.aer_ready = 1'b0;
    strobe(8'hFF);
    repeat (4) tick();
    chk("pp_fill", 32'(fifo_count), 32'd4);
    u_if.aer_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("pp_steady_%0d", k), 32'(fifo_count), 32'd4);
      if (u_if.aer_valid) begin
        q_addr.push_back(int'(u_if.aer_addr));
        q_ts.push_back(int'(u_if.aer_ts));
      end
      tick();
    end
    collect(3, 10, cyc);
    for (int i = 0; i < 8; i++) expect_ev($sformatf("pp_%0d", i), i, 2);
    chk("pp_empty", 32'(u_if.aer_valid), 32'd0);
    chk("pp_extra", 32'(q_addr.size()), 32'd0);

    // Drop saturation and clear priority.
    u_if.aer_ready = 1'b0;
    strobe(8'hFF);
    repeat (8) tick();
    strobe(8'hFF);
    spike       = 8'hFF;
    spike_valid = 1'b1;
    repeat (31) tick();
    chk("sat_248", 32'(drop_count), 32'd248);
    chk("sat_overrun", 32'(overrun), 32'd1);
    tick();
    chk("sat_255", 32'(drop_count), 32'd255);
    tick();
    chk("sat_hold", 32'(drop_count), 32'd255);
    chk("sat_full", 32'(fifo_count), 32'd8);
    spike    = 8'h01;
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("clr_drop", 32'(drop_count), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);
    tick();
    chk("after_clr_drop", 32'(drop_count), 32'd1);
    chk("after_clr_overrun", 32'(overrun), 32'd1);
    spike = 8'h00;
    tick();
    spike_valid = 1'b0;
    chk("zero_drop", 32'(drop_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
